jt053247_draw: RTL
==================

// Module: jt053247_draw
// PURPOSE
//  Object draw stage downstream of the jt053246 sprite scanner. Takes one
//  16-pixel tile-row request (code/attr/hpos/ysub/zoom/flip) per dr_start,
//  fetches 2x32-bit words from object ROM, applies horizontal flip and zoom,
//  and writes opaque pixels into the external line buffer. Drives dr_busy back.
// PARAMETERS
//  PXL_BUDGET  10'd640  max line-buffer write cycles per scan line (budget feature)
//  MAXW        9'd256   max output pixels per request (caps extreme enlargement)
// PORTS
//  clk       in   1   clock
//  rst       in   1   reset, asynchronous, active-high
//  cen       in   1   clock enable; all state advances only when cen=1
//  hs        in   1   horizontal sync; rising edge = new line (budget feature)
//  dr_start  in   1   draw request strobe, one cen cycle long
//  dr_busy   out  1   request in progress
//  code      in   16  tile code
//  attr      in   10  palette/priority attributes
//  shd       in   2   shadow mode
//  hflip     in   1   horizontal flip
//  hpos      in   9   left screen column of the request
//  ysub      in   4   row inside tile
//  hzoom     in   12  horizontal zoom, 0x40 = 1:1
//  hz_keep   in   1   continue previous tile's x position and zoom phase
//  rom_addr  out  21  {code,ysub,half}
//  rom_cs    out  1   ROM read request
//  rom_ok    in   1   rom_data valid for current rom_addr
//  rom_data  in   32  8 packed pixels, pixel i at [4i+3:4i], pixel 0 leftmost
//  buf_addr  out  9   line-buffer column
//  buf_din   out  16  {shd,attr,pix}
//  buf_we    out  1   line-buffer write strobe
// BEHAVIOUR
//  Reset: dr_busy=0, rom_cs=0, buf_we=0, rom_addr=0, buf_addr=0, buf_din=0, state=IDLE.
//  FSM IDLE->FETCH0->FETCH1->DRAW->IDLE.
//  IDLE: on dr_start latch all request inputs; dr_busy=1 on next cen cycle.
//   dr_start while dr_busy=1 is ignored (scanner must not issue it).
//  FETCH0: rom_addr={code,ysub,1'b0}, rom_cs=1; wait rom_ok; store low 8 pixels.
//  FETCH1: same with half=1; on rom_ok store high 8 pixels, rom_cs=0.
//   rom_ok must be qualified by an address change: ignored on the cycle rom_addr changes.
//  DRAW: one pixel per cen cycle. Source phase sx, 10-bit with 6 fraction bits.
//   Effective zoom z = hzoom[11:10]!=0 ? 10'h3FF : (hzoom[9:0]==0 ? 1 : hzoom[9:0]).
//   Each cycle: src=sx[9:6]; pix = pixels[hflip ? 15-src : src];
//   buf_we = (pix!=0); buf_din={shd,attr,pix}; buf_addr=col; col+=1 (mod 512);
//   sx += z. Ends when sx carries past 16.0 (sx>=1024) or MAXW pixels emitted.
//   Example: z=0x40 -> 16 writes; z=0x20 -> 32; z=0x80 -> 8.
//  hz_keep=0: col=hpos, sx=0. hz_keep=1: col and sx continue from the end of the
//   previous request (sx keeps fraction, integer part cleared), hpos ignored.
//  End of DRAW: buf_we=0, dr_busy=0 on the same cen cycle that state returns to IDLE.
//  Column wrap: col 511 -> 0 continues writing; no clipping here.
//  Reset mid-request: immediate return to IDLE, all strobes low, kept phase cleared.
// CONFIGURATION
//  JT053247_PXLBUDGET_EN defined: counter cleared on hs rising edge, +1 per DRAW
//   cycle; when count>=PXL_BUDGET, DRAW stops (buf_we=0, back to IDLE) and new
//   requests are acknowledged in one cycle with no ROM fetch; dr_busy still
//   pulses for one cycle.
//  Not defined: no budget, hs unused, every request fully drawn.
// TESTING
//  1 hzoom=0x40, hflip=0, hpos=0x20, rom words 0x76543210/0xFEDCBA98 -> 15 writes at
//    0x21..0x2F with pix 1..F, column 0x20 skipped (pix 0), dr_busy low after.
//  2 same with hflip=1 -> pix F at 0x20 ... pix 1 at 0x2E, no write at 0x2F.
//  3 hzoom=0x20 -> 32 write cycles, each source pixel twice; hzoom=0x80 -> 8 cycles, even pixels.
//  4 two requests, 2nd hz_keep=1, hzoom=0x30, 2nd hpos=0 -> 2nd starts at col 0x20+22,
//    no gap or overlap vs first.
//  5 rom_ok held low 20 cycles in FETCH0 -> rom_cs stays 1, no buf_we, dr_busy stays 1;
//    rst pulse during DRAW -> buf_we/dr_busy 0 next cycle.
//  6 with JT053247_PXLBUDGET_EN, PXL_BUDGET=20: two 1:1 requests in one line -> 16 + 4
//    draw cycles; after hs rising edge full 16 again.

Source files
------------

// File: rtl/jt053247_draw.sv
// Object draw stage: fetches one 16-pixel tile row from ROM and writes flipped/zoomed
// opaque pixels to the line buffer. Optional per-line pixel budget: JT053247_PXLBUDGET_EN.
module jt053247_draw #(
  parameter logic [9:0] PXL_BUDGET = 10'd640,
  parameter logic [8:0] MAXW       = 9'd256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        hs,
  input  logic        dr_start,
  output logic        dr_busy,
  input  logic [15:0] code,
  input  logic [9:0]  attr,
  input  logic [1:0]  shd,
  input  logic        hflip,
  input  logic [8:0]  hpos,
  input  logic [3:0]  ysub,
  input  logic [11:0] hzoom,
  input  logic        hz_keep,
  output logic [20:0] rom_addr,
  output logic        rom_cs,
  input  logic        rom_ok,
  input  logic [31:0] rom_data,
  output logic [8:0]  buf_addr,
  output logic [15:0] buf_din,
  output logic        buf_we
);

  typedef enum logic [1:0] {IDLE, FETCH0, FETCH1, DRAW} state_t;

  state_t      st, st_nxt;
  logic [15:0] code_r;
  logic [3:0]  ysub_r;
  logic [9:0]  attr_r;
  logic [1:0]  shd_r;
  logic        hflip_r;
  logic [9:0]  z_r, z_eff;
  logic [63:0] pixels;
  logic [8:0]  col, nout, nout_inc;
  logic [9:0]  sx;
  logic [10:0] sx_sum;
  logic [3:0]  idx, pix;
  logic        ok_arm, over;
  logic        latch, take0, take1, step, finish, draw_we;

  assign z_eff    = (hzoom[11:10] != 2'd0) ? 10'h3FF :
                    (hzoom[9:0] == 10'd0)  ? 10'd1   : hzoom[9:0];
  assign sx_sum   = {1'b0, sx} + {1'b0, z_r};
  assign nout_inc = nout + 9'd1;
  assign idx      = hflip_r ? ~sx[9:6] : sx[9:6];
  assign pix      = pixels[{idx, 2'b00} +: 4];

  assign dr_busy  = (st != IDLE);
  assign rom_cs   = (st == FETCH0) || (st == FETCH1);
  assign rom_addr = {code_r, ysub_r, st == FETCH1};
  assign buf_addr = col;
  assign buf_din  = {shd_r, attr_r, pix};
  assign buf_we   = cen & draw_we;

  always_comb begin
    st_nxt  = st;
    latch   = 1'b0;
    take0   = 1'b0;
    take1   = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    draw_we = 1'b0;
    case (st)
      IDLE:
        if (dr_start) begin
          latch  = 1'b1;
          st_nxt = over ? DRAW : FETCH0;
        end
      FETCH0:
        if (rom_ok && ok_arm) begin
          take0  = 1'b1;
          st_nxt = FETCH1;
        end
      FETCH1:
        if (rom_ok && ok_arm) begin
          take1  = 1'b1;
          st_nxt = DRAW;
        end
      DRAW:
        if (over) begin
          finish = 1'b1;
          st_nxt = IDLE;
        end else begin
          step    = 1'b1;
          draw_we = (pix != 4'd0);
          if (sx_sum[10] || nout_inc == MAXW) begin
            finish = 1'b1;
            st_nxt = IDLE;
          end
        end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      code_r  <= '0;
      ysub_r  <= '0;
      attr_r  <= '0;
      shd_r   <= '0;
      hflip_r <= 1'b0;
      z_r     <= '0;
      pixels  <= '0;
      col     <= '0;
      sx      <= '0;
      nout    <= '0;
      ok_arm  <= 1'b0;
    end else if (cen) begin
      st     <= st_nxt;
      // rom_addr changes on these transitions, so the following rom_ok is stale
      ok_arm <= !(latch || take0);
      if (latch) begin
        code_r  <= code;
        ysub_r  <= ysub;
        attr_r  <= attr;
        shd_r   <= shd;
        hflip_r <= hflip;
        z_r     <= z_eff;
        nout    <= '0;
        if (!hz_keep) begin
          col <= hpos;
          sx  <= '0;
        end
      end
      if (take0) pixels[31:0]  <= rom_data;
      if (take1) pixels[63:32] <= rom_data;
      if (step) begin
        col  <= col + 9'd1;
        nout <= nout_inc;
        sx   <= sx_sum[9:0];
      end
      // only the fractional phase carries into an hz_keep continuation
      if (finish) sx <= {4'd0, step ? sx_sum[5:0] : sx[5:0]};
    end
  end

`ifdef JT053247_PXLBUDGET_EN
  logic       hs_l;
  logic [9:0] bcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_l <= 1'b0;
      bcnt <= '0;
    end else if (cen) begin
      hs_l <= hs;
      if (hs && !hs_l) bcnt <= '0;
      else if (step)   bcnt <= bcnt + 10'd1;
    end
  end

  assign over = (bcnt >= PXL_BUDGET);
`else
  logic unused_budget;
  assign over          = 1'b0;
  assign unused_budget = ^{hs, PXL_BUDGET};
`endif

endmodule
